clk_gen_bank: RTL and testbench
===============================

Name: clk_gen_bank

Overview:
- Multi-channel programmable clock generator running from the 1 MHz system clock.
- Converts an 8-bit frequency code per channel into a half-period count:
  - f_out = F_STEP*code + F_MIN
  - half = floor(F_REF/(2*f_out))
- Conversion is done by one shared iterative divider behind a valid/ready config port.
- New half-periods take effect only at a half-period boundary, so channel outputs never glitch.
- Serves as the clock source bank for the sampling and modulation blocks.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16)
- PARAM_W, 8, width of the frequency code
- CNT_W, 16, width of the half-period counters and registers
- F_REF, 1000000, input clock frequency in Hz
- F_MIN, 6000, output frequency in Hz for code 0
- F_STEP, 367, Hz per code LSB
- DIV_W, 32, width of the dividend and divisor in the divider

Ports:
- clk_in  in  1  system clock (1 MHz), rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config port can accept a request
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel
- cfg_param  in  PARAM_W  frequency code
- cfg_done  out  1  one-cycle pulse: result committed to shadow
- cfg_done_ch  out  clog2(NUM_CH)  channel of the cfg_done pulse
- ch_en  in  NUM_CH  per-channel run enable
- clk_out  out  NUM_CH  generated clocks, registered

Behaviour:
- Reset (async on rst_n low, released synchronously to clk_in):
  - clk_out=0, cfg_ready=1, cfg_done=0, cfg_done_ch=0
  - all counters=0, all pending flags=0
  - active and shadow half-period = HALF_RST = floor(F_REF/(2*F_MIN)) = 83
  - FSM in IDLE
- Config FSM states: IDLE -> CALC -> COMMIT -> IDLE.
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, latch cfg_ch and cfg_param, form divisor=2*(F_STEP*param+F_MIN) at DIV_W bits, start the divider, go to CALC.
  - CALC: cfg_ready=0. Restoring divider produces 1 quotient bit per cycle for DIV_W cycles, then goes to COMMIT.
  - COMMIT: clamp the quotient to [1, 2^CNT_W-1], write it to shadow[ch], set pending[ch], pulse cfg_done with cfg_done_ch=ch, return to IDLE.
- Latency from accept to cfg_done is DIV_W+2 cycles (34 by default). cfg_ready returns high the cycle after cfg_done.
- Requests arriving while cfg_ready=0 are not accepted. The requester holds cfg_valid.
- Out-of-range cfg_ch (>= NUM_CH) is accepted, the division runs, cfg_done pulses, and no channel state changes.
- Channel i with ch_en[i]=1, every cycle:
  - If counter == active-1: counter<=0, clk_out[i] toggles, and if pending[i] then active<=shadow and pending<=0.
  - Otherwise counter increments.
  - Output period is 2*active cycles, 50% duty.
- A COMMIT to channel i in the same cycle as its boundary: the boundary uses the old active/shadow; new shadow and pending=1 win; the new value applies at the next boundary.
- ch_en[i]=0: clk_out[i]<=0 and counter<=0 on the next edge. If pending[i], active<=shadow immediately.
- Re-enable starts a low phase of exactly active cycles.
- A reset mid-CALC aborts the conversion. No cfg_done is issued.

Decomposition:
- Shared package clk_gen_pkg: F_REF, F_MIN, F_STEP, HALF_RST, FSM state enum (IDLE, CALC, COMMIT), and the clamp function.
- One sub-module, seq_divider (start, dividend, divisor -> busy, done, quotient), a DIV_W-cycle restoring divider reusable elsewhere.
- Channel counters are generated inline.

Test Plan:
- Reset, ch_en=4'b1111, no config -> all clk_out toggle every 83 cycles (period 166) and are mutually in phase from reset release.
- cfg ch1 param 255 -> cfg_done after 34 cycles with cfg_done_ch=1. f=99585, half=5, applied at ch1's next boundary. No high or low pulse shorter than min(old, new) half. Other channels stay at 83.
- cfg ch2 param 128 -> half=9 (f=52976) applied at boundary. Second request during CALC keeps cfg_ready=0 until cfg_done. cfg_valid held -> accepted the cycle cfg_ready returns.
- COMMIT timed to coincide with ch0's boundary -> that boundary keeps the old half. The new half applies one half-period later.
- Deassert ch_en[3] mid-high-phase -> clk_out[3]=0 next cycle. Re-assert -> low for exactly active cycles, then high.
- Assert rst_n=0 during CALC -> outputs 0 immediately (async). After release, cfg_done does not pulse and all halves are back to 83.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants, config FSM state type and half-period clamp for the clock generator bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_gen_pkg;

    localparam int F_REF    = 1000000;
    localparam int F_MIN    = 6000;
    localparam int F_STEP   = 367;
    localparam int HALF_RST = F_REF / (2 * F_MIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // A zero half-period would stall a channel and anything above the counter
    // range would wrap, so both ends are pinned.
    function automatic logic [31:0] clamp_half(input logic [31:0] q, input logic [31:0] max_v);
        if (q == 32'd0) begin
            return 32'd1;
        end else if (q > max_v) begin
            return max_v;
        end else begin
            return q;
        end
    endfunction

endpackage

// File: rtl/clk_gen_bank_if.sv
// Config request/completion port of the clock generator bank.
// Latency: n/a (wiring only).
// Backpressure: requester holds cfg_valid until cfg_ready is seen high at a clock edge.
interface clk_gen_bank_if #(
    parameter int NUM_CH  = 4,
    parameter int PARAM_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [PARAM_W-1:0] cfg_param;
    logic               cfg_done;
    logic [CH_W-1:0]    cfg_done_ch;

    modport master (
        output cfg_valid, cfg_ch, cfg_param,
        input  cfg_ready, cfg_done, cfg_done_ch
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_param,
        output cfg_ready, cfg_done, cfg_done_ch
    );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: W iteration cycles after the start edge, done pulses on the following cycle.
// Backpressure: none; a start while busy restarts the division.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_quotient
);

    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_END = CW'(W);

    logic [W:0]    r_rem;
    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_quo;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [W:0]    w_trial;
    logic          w_fits;

    assign w_trial    = {r_rem[W-1:0], r_dvd[W-1]};
    assign w_fits     = (w_trial >= {1'b0, r_dvs});
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

    // Shift-subtract loop; done is registered one cycle after the last quotient bit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_dvd  <= i_dividend;
                r_dvs  <= i_divisor;
                r_quo  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt == CNT_END) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_rem <= w_fits ? (w_trial - {1'b0, r_dvs}) : w_trial;
                    r_dvd <= r_dvd << 1;
                    r_quo <= {r_quo[W-2:0], w_fits};
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_gen_bank.sv
// Bank of programmable 50%-duty clocks; frequency codes are converted to half-periods by one shared divider.
// Latency: config accept to cfg_done is DIV_W+2 cycles; new half-period applies at the channel's next boundary.
// Backpressure: cfg_ready is low from accept until the cycle after cfg_done; requests are held by the requester.
module clk_gen_bank #(
    parameter int NUM_CH  = 4,
    parameter int PARAM_W = 8,
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 32,
    parameter int F_REF   = clk_gen_pkg::F_REF,
    parameter int F_MIN   = clk_gen_pkg::F_MIN,
    parameter int F_STEP  = clk_gen_pkg::F_STEP
) (
    input  logic              clk_in,
    input  logic              rst_n,
    clk_gen_bank_if.slave     cfg,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out
);
    import clk_gen_pkg::*;

    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(F_REF / (2 * F_MIN));
    localparam logic [DIV_W-1:0] DIVIDEND  = DIV_W'(F_REF);
    localparam logic [DIV_W-1:0] STEP_C    = DIV_W'(F_STEP);
    localparam logic [DIV_W-1:0] MIN_C     = DIV_W'(F_MIN);
    localparam logic [31:0]      HALF_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [CH_W-1:0]  r_ch;
    logic             w_accept;
    logic             w_commit;
    logic             w_div_busy;
    logic             w_div_done;
    logic [DIV_W-1:0] w_divisor;
    logic [DIV_W-1:0] w_quotient;
    logic [CNT_W-1:0] w_half;

    // Divisor is twice the output frequency, so the quotient is a half-period in input cycles.
    assign w_divisor = (STEP_C * DIV_W'(cfg.cfg_param) + MIN_C) << 1;
    assign w_half    = CNT_W'(clamp_half(32'(w_quotient), HALF_MAX));

    assign cfg.cfg_ready   = (r_state == IDLE) && !w_div_busy;
    assign cfg.cfg_done    = (r_state == COMMIT);
    assign cfg.cfg_done_ch = r_ch;

    seq_divider #(.W(DIV_W)) u_div (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .i_start    (w_accept),
        .i_dividend (DIVIDEND),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    // Config FSM state and the latched target channel.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ch <= cfg.cfg_ch;
            end
        end
    end

    // Config FSM next state: accept in IDLE, wait for the divider, commit for one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg.cfg_valid && !w_div_busy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_div_done) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] r_shadow;
        logic             r_pending;
        logic             r_clk;
        logic             w_load;

        // Out-of-range channel numbers match no channel and are dropped here.
        assign w_load     = w_commit && (r_ch == CH_W'(i));
        assign clk_out[i] = r_clk;

        // Half-period counter; shadow moves to active only at a boundary or while stopped,
        // and a same-cycle commit re-arms pending after the boundary consumed the old one.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt     <= '0;
                r_active  <= HALF_INIT;
                r_shadow  <= HALF_INIT;
                r_pending <= 1'b0;
                r_clk     <= 1'b0;
            end else begin
                if (!ch_en[i]) begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (r_pending) begin
                        r_active  <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else if (r_cnt == r_active - CNT_W'(1)) begin
                    r_cnt <= '0;
                    r_clk <= ~r_clk;
                    if (r_pending) begin
                        r_active  <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_load) begin
                    r_shadow  <= w_half;
                    r_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_bank.sv
// Randomized bench for clk_gen_bank against an event-based model of toggle times.
// Latency: model predicts cfg_done 34 cycles after accept and commit on the following edge.
// Backpressure: requests are held until the model sees them accepted.
`timescale 1ns/1ps
module tb_clk_gen_bank;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int T_REF  = 1000000;
    localparam int T_MIN  = 6000;
    localparam int T_STEP = 367;
    localparam int H0     = 83;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] clk_out;

    clk_gen_bank_if #(.NUM_CH(NUM_CH), .PARAM_W(8)) bus ();

    clk_gen_bank #(.NUM_CH(NUM_CH)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .cfg     (bus),
        .ch_en   (ch_en),
        .clk_out (clk_out)
    );

    always #500 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Model state: per channel level, current and queued half-period, absolute edge of next toggle.
    int n_now = 0;
    int m_level [NUM_CH];
    int m_active[NUM_CH];
    int m_pend  [NUM_CH];
    int m_next  [NUM_CH];
    bit m_job = 1'b0;
    int m_acc = 0;
    int m_job_ch = 0;
    int m_job_half = 0;
    int m_acc_cnt = 0;

    function automatic int exp_half(input int p);
        int f;
        int h;
        f = T_STEP * p + T_MIN;
        h = T_REF / (2 * f);
        if (h < 1) h = 1;
        if (h > 65535) h = 65535;
        return h;
    endfunction

    task automatic model_step();
        bit rdy_before;
        rdy_before = !m_job;
        n_now++;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_level[i]  = 0;
                m_active[i] = H0;
                m_pend[i]   = 0;
                m_next[i]   = n_now + H0;
            end
            m_job = 1'b0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                m_level[i] = 0;
                if (m_pend[i] != 0) begin
                    m_active[i] = m_pend[i];
                    m_pend[i]   = 0;
                end
                m_next[i] = n_now + m_active[i];
            end else if (n_now == m_next[i]) begin
                m_level[i] = 1 - m_level[i];
                if (m_pend[i] != 0) begin
                    m_active[i] = m_pend[i];
                    m_pend[i]   = 0;
                end
                m_next[i] = n_now + m_active[i];
            end
        end
        if (m_job && n_now == m_acc + 35) begin
            if (m_job_ch < NUM_CH) m_pend[m_job_ch] = m_job_half;
            m_job = 1'b0;
        end
        if (bus.cfg_valid && rdy_before) begin
            m_job      = 1'b1;
            m_acc      = n_now;
            m_job_ch   = int'(bus.cfg_ch);
            m_job_half = exp_half(int'(bus.cfg_param));
            m_acc_cnt++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            model_step();
        end
    end

    // Every cycle: compare outputs to the model away from the active edge.
    initial begin
        logic [NUM_CH-1:0] e_out;
        bit e_done;
        forever begin
            @(negedge clk_in);
            e_out = '0;
            if (!rst_n) begin
                chk_val("rst_clk_out", clk_out, 0);
                chk_val("rst_cfg_ready", bus.cfg_ready, 1);
                chk_val("rst_cfg_done", bus.cfg_done, 0);
            end else begin
                for (int i = 0; i < NUM_CH; i++) e_out[i] = (m_level[i] != 0);
                e_done = m_job && (n_now == m_acc + 34);
                chk_val("clk_out", clk_out, e_out);
                chk_val("cfg_ready", bus.cfg_ready, !m_job);
                chk_val("cfg_done", bus.cfg_done, e_done);
                if (e_done) chk_val("cfg_done_ch", bus.cfg_done_ch, m_job_ch);
            end
        end
    end

    task automatic do_cfg(input int ch, input int p);
        int c0;
        bit ok;
        logic [31:0] chv;
        logic [31:0] pv;
        c0 = m_acc_cnt;
        ok = 1'b0;
        chv = ch;
        pv  = p;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = chv[CH_W-1:0];
        bus.cfg_param = pv[7:0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            if (m_acc_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cfg_valid = 1'b0;
        if (!ok) chk_val("cfg_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!m_job && m_pend[0] == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (!ok) chk_val("idle_timeout", 0, 1);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        int t;
        int p;
        bit ok;
        rst_n         = 1'b0;
        ch_en         = '1;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_param = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_level[i] = 0; m_active[i] = H0; m_pend[i] = 0; m_next[i] = H0;
        end
        repeat (3) @(negedge clk_in);
        #2 rst_n = 1'b1;

        // Free running at the reset half-period, all channels in phase.
        repeat (400) @(negedge clk_in);

        // Fastest code on ch1, then ch2 with a second request held through CALC.
        do_cfg(1, 255);
        repeat (150) @(negedge clk_in);
        do_cfg(2, 128);
        do_cfg(0, $urandom_range(0, 255));
        repeat (300) @(negedge clk_in);

        // Commit landing exactly on a ch0 boundary.
        wait_idle();
        p = (m_active[0] == 5) ? 0 : 255;
        t = m_next[0];
        while (t - 36 <= n_now) t += m_active[0];
        for (int k = 0; k < 3000 && n_now < t - 36; k++) @(negedge clk_in);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = '0;
        bus.cfg_param = p[7:0];
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        repeat (300) @(negedge clk_in);

        // Stop ch3 mid-high, reprogram it while stopped, restart.
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_in);
            if (m_level[3] == 1 && m_next[3] - n_now == 40) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_val("ch3_phase_timeout", 0, 1);
        ch_en[3] = 1'b0;
        repeat (17) @(negedge clk_in);
        ch_en[3] = 1'b1;
        repeat (200) @(negedge clk_in);
        ch_en[3] = 1'b0;
        do_cfg(3, 255);
        repeat (40) @(negedge clk_in);
        ch_en[3] = 1'b1;
        repeat (100) @(negedge clk_in);

        // Random traffic with occasional enable changes.
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 3) == 0) ch_en = 4'($urandom);
            do_cfg($urandom_range(0, NUM_CH - 1), $urandom_range(0, 255));
            repeat ($urandom_range(0, 120)) @(negedge clk_in);
        end
        ch_en = '1;
        repeat (300) @(negedge clk_in);

        // Reset in the middle of a conversion.
        do_cfg(1, $urandom_range(0, 255));
        repeat (10) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk_val("arst_clk_out", clk_out, 0);
        chk_val("arst_cfg_ready", bus.cfg_ready, 1);
        chk_val("arst_cfg_done", bus.cfg_done, 0);
        repeat (2) @(negedge clk_in);
        #2 rst_n = 1'b1;
        repeat (400) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
